fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter sharing one fifo write port among NUM_REQ producers.
//   Each producer uses a valid/ready handshake. A winner owns the port for a burst of
//   up to MAX_BURST beats, then ownership rotates. No data buffering: fifo_wdata is a
//   mux of the owner's req_data. Sits directly in front of the fifo wr_en/wdata/full port.
// PARAMETERS
//   NUM_REQ     4   number of producers (>=1)
//   DATA_WIDTH  8   word width, matches fifo DATA_WIDTH
//   MAX_BURST   4   max beats per grant (>=1)
// PORTS
//   clk          in   1                     clock, all logic on posedge
//   rst          in   1                     synchronous reset, active-high
//   req_valid    in   NUM_REQ               producer i has a word
//   req_data     in   NUM_REQ*DATA_WIDTH    producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    out  NUM_REQ               producer i word accepted this cycle if valid
//   fifo_wr_en   out  1                     to fifo wr_en
//   fifo_wdata   out  DATA_WIDTH            to fifo wdata
//   fifo_full    in   1                     from fifo full
//   grant_valid  out  1                     a producer currently owns the port
//   grant_id     out  $clog2(NUM_REQ) (min 1) current owner index
// BEHAVIOUR
//   Registers: state {IDLE,OWN}, owner, beats (width $clog2(MAX_BURST+1)), last (rr pointer).
//   Reset: state=IDLE, owner=0, beats=0, last=NUM_REQ-1 (req 0 wins first).
//   req_ready, fifo_wr_en, grant_valid forced 0 in any cycle rst is high.
//   IDLE: pick first i with req_valid[i], searching last+1, last+2, ... mod NUM_REQ.
//     If one exists: next state OWN, owner<=i, beats<=0. No transfer in IDLE (1-cycle bubble).
//     fifo_full does not block arbitration.
//   OWN: req_ready[owner] = !fifo_full; all other req_ready = 0.
//     fifo_wr_en = req_valid[owner] && !fifo_full; fifo_wdata = req_data slice of owner
//     (driven from owner slice in all states; value irrelevant when fifo_wr_en=0).
//     Transfer (fifo_wr_en=1): beats<=beats+1.
//     Release to IDLE, last<=owner, when either:
//       - transfer occurs with beats==MAX_BURST-1 (burst done), or
//       - req_valid[owner]==0 (producer went idle; no transfer that cycle).
//     fifo_full with owner valid: hold owner and beats, no release (stall).
//   grant_valid = (state==OWN); grant_id = owner.
//   Producer rule: req_data[i] held stable while req_valid[i] && !req_ready[i].
//   Throughput: full burst of B beats uses B+1 cycles with fifo not full.
//   NUM_REQ=1: same FSM, owner always 0, bubble after every burst.
//   Reset mid-burst: next cycle IDLE, last=NUM_REQ-1; beats accepted before reset stand.
//   Fairness: every continuously valid producer is granted within NUM_REQ-1 other
//   grants; grant_id changes only via an IDLE cycle.
// TESTING
//   1 rst=1 2 cycles, req_valid=4'b1111 -> req_ready=0, fifo_wr_en=0, grant_valid=0;
//     after release: IDLE cycle, then grant_id=0.
//   2 req_valid=4'b1111 steady, fifo_full=0, data_i=8'hi0+beat -> grants 0,1,2,3,0,
//     4 writes each, one bubble between; 16 writes in 20 cycles, order 00..03,10..13,...
//   3 only req 1 valid, drops valid after 2 beats -> IDLE next cycle; req 2 valid then
//     -> grant_id=2 one cycle later; req 1 gets 2 writes only.
//   4 owner req 0 mid-burst (beats=2), fifo_full=1 for 3 cycles -> fifo_wr_en=0,
//     req_ready=0, grant_id=0, beats=2 held; then 2 more writes and release.
//   5 rst pulsed 1 cycle during burst of req 2 -> next cycle IDLE; with 4'b1111 valid
//     the next grant is req 0, not req 3.
//   6 only req 3 valid continuously, MAX_BURST=4 -> re-granted to 3 each time,
//     pattern 4 writes + 1 bubble, fifo_wdata always req 3 slice.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready producers.
// A winner owns the port for up to MAX_BURST beats; ownership changes only through IDLE.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [ID_W-1:0]   last_q, last_d;

  logic              found;
  logic [ID_W-1:0]   idx;

  // State register; reset leaves last at NUM_REQ-1 so producer 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      beats_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
      last_q  <= last_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beats_d    = beats_q;
    last_d     = last_q;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    found      = 1'b0;
    idx        = '0;

    case (state_q)
      IDLE: begin
        // Rotating priority search starting just after the previous owner.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
          idx = ID_W'((32'(last_q) + k) % NUM_REQ);
          if (!found && req_valid[idx]) begin
            found   = 1'b1;
            owner_d = idx;
          end
        end
        if (found) begin
          state_d = OWN;
          beats_d = '0;
        end
      end
      OWN: begin
        req_ready[owner_q] = !fifo_full;
        fifo_wr_en         = req_valid[owner_q] && !fifo_full;
        if (!req_valid[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (fifo_wr_en) begin
          beats_d = beats_q + BEAT_W'(1);
          if (beats_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
    end
  end

  assign fifo_wdata  = req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
  assign grant_valid = (state_q == OWN) && !rst;
  assign grant_id    = owner_q;

endmodule
